// File: rtl/piece_cell_checker.sv
// Sequential piece cell checker: derives a piece's four board cells and bounding box,
// bounds-checks it, then reads each cell from board RAM to detect collisions.
module piece_cell_checker #(
    parameter int BLOCKS_WIDE    = 14,
    parameter int BLOCKS_HIGH    = 20,
    parameter int BITS_PER_BLOCK = 3,
    parameter int X_W            = 4,
    parameter int Y_W            = 5,
    parameter int IDX_W          = 8,
    parameter int EARLY_EXIT     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BITS_PER_BLOCK-1:0] piece,
    input  logic [X_W-1:0]            pos_x,
    input  logic [Y_W-1:0]            pos_y,
    input  logic [1:0]                rot,
    output logic                      rd_en,
    output logic [IDX_W-1:0]          rd_addr,
    input  logic [BITS_PER_BLOCK-1:0] rd_data,
    output logic                      done,
    output logic                      collide,
    output logic                      oob,
    output logic [IDX_W-1:0]          blk_1,
    output logic [IDX_W-1:0]          blk_2,
    output logic [IDX_W-1:0]          blk_3,
    output logic [IDX_W-1:0]          blk_4,
    output logic [2:0]                width,
    output logic [2:0]                height
);

    localparam int AW = IDX_W + 1;
    localparam logic [BITS_PER_BLOCK-1:0] EMPTY_BLOCK = BITS_PER_BLOCK'(0);
    localparam logic [BITS_PER_BLOCK-1:0] P_I = BITS_PER_BLOCK'(1);
    localparam logic [BITS_PER_BLOCK-1:0] P_O = BITS_PER_BLOCK'(2);
    localparam logic [BITS_PER_BLOCK-1:0] P_T = BITS_PER_BLOCK'(3);
    localparam logic [BITS_PER_BLOCK-1:0] P_S = BITS_PER_BLOCK'(4);
    localparam logic [BITS_PER_BLOCK-1:0] P_Z = BITS_PER_BLOCK'(5);
    localparam logic [BITS_PER_BLOCK-1:0] P_J = BITS_PER_BLOCK'(6);
    localparam logic [BITS_PER_BLOCK-1:0] P_L = BITS_PER_BLOCK'(7);

    typedef enum logic [2:0] {IDLE, CALC, READ, DRAIN, DONE} state_t;

    // Shape word: four {dx,dy} nibbles (blk_1 first), then width, then height.
    // An all-zero word marks an empty or unrecognised piece.
    function automatic logic [21:0] shape(input logic [BITS_PER_BLOCK-1:0] p, input logic [1:0] r);
        case (p)
            P_I: shape = r[0] ? {16'h048C, 3'd4, 3'd1} : {16'h0123, 3'd1, 3'd4};
            P_O: shape = {16'h0415, 3'd2, 3'd2};
            P_T: case (r)
                2'd0:    shape = {16'h4159, 3'd3, 3'd2};
                2'd1:    shape = {16'h0125, 3'd2, 3'd3};
                2'd2:    shape = {16'h0485, 3'd3, 3'd2};
                default: shape = {16'h4561, 3'd2, 3'd3};
            endcase
            P_S: shape = r[0] ? {16'h0156, 3'd2, 3'd3} : {16'h4815, 3'd3, 3'd2};
            P_Z: shape = r[0] ? {16'h4125, 3'd2, 3'd3} : {16'h0459, 3'd3, 3'd2};
            P_J: case (r)
                2'd0:    shape = {16'h4562, 3'd2, 3'd3};
                2'd1:    shape = {16'h0159, 3'd3, 3'd2};
                2'd2:    shape = {16'h0124, 3'd2, 3'd3};
                default: shape = {16'h0489, 3'd3, 3'd2};
            endcase
            P_L: case (r)
                2'd0:    shape = {16'h0126, 3'd2, 3'd3};
                2'd1:    shape = {16'h1048, 3'd3, 3'd2};
                2'd2:    shape = {16'h4560, 3'd2, 3'd3};
                default: shape = {16'h1598, 3'd3, 3'd2};
            endcase
            default: shape = 22'd0;
        endcase
    endfunction

    state_t                    state_r;
    logic [BITS_PER_BLOCK-1:0] piece_r;
    logic [X_W-1:0]            pos_x_r;
    logic [Y_W-1:0]            pos_y_r;
    logic [1:0]                rot_r;
    logic [1:0]                cnt_r;
    logic                      pend_r;
    logic [IDX_W-1:0]          blk_r [4];

    logic [21:0]      shape_s;
    logic [IDX_W-1:0] cell_s [4];
    logic [2:0]       width_s;
    logic [2:0]       height_s;
    logic             empty_s;
    logic             oob_s;
    logic             hit_s;

    // Cell indices, bounding box and bounds check from the latched request.
    always_comb begin
        shape_s  = shape(piece_r, rot_r);
        width_s  = shape_s[5:3];
        height_s = shape_s[2:0];
        empty_s  = (shape_s == 22'd0);
        for (int k = 0; k < 4; k++) begin
            cell_s[k] = IDX_W'((AW'(pos_y_r) + AW'(shape_s[19-4*k -: 2])) * AW'(BLOCKS_WIDE)
                               + AW'(pos_x_r) + AW'(shape_s[21-4*k -: 2]));
        end
        oob_s = !empty_s && ((AW'(pos_x_r) + AW'(width_s) > AW'(BLOCKS_WIDE)) ||
                             (AW'(pos_y_r) + AW'(height_s) > AW'(BLOCKS_HIGH)));
        hit_s = pend_r && (rd_data != EMPTY_BLOCK);
    end

    assign blk_1 = blk_r[0];
    assign blk_2 = blk_r[1];
    assign blk_3 = blk_r[2];
    assign blk_4 = blk_r[3];

    // Control FSM with registered handshake, read port and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            piece_r   <= EMPTY_BLOCK;
            pos_x_r   <= X_W'(0);
            pos_y_r   <= Y_W'(0);
            rot_r     <= 2'd0;
            cnt_r     <= 2'd0;
            pend_r    <= 1'b0;
            req_ready <= 1'b1;
            rd_en     <= 1'b0;
            rd_addr   <= IDX_W'(0);
            done      <= 1'b0;
            collide   <= 1'b0;
            oob       <= 1'b0;
            width     <= 3'd0;
            height    <= 3'd0;
            for (int k = 0; k < 4; k++) blk_r[k] <= '1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        piece_r   <= piece;
                        pos_x_r   <= pos_x;
                        pos_y_r   <= pos_y;
                        rot_r     <= rot;
                        collide   <= 1'b0;
                        oob       <= 1'b0;
                        req_ready <= 1'b0;
                        state_r   <= CALC;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CALC: begin
                    width  <= width_s;
                    height <= height_s;
                    oob    <= oob_s;
                    for (int k = 0; k < 4; k++) blk_r[k] <= empty_s ? '1 : cell_s[k];
                    if (empty_s || oob_s) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= cell_s[0];
                        cnt_r   <= 2'd0;
                        state_r <= READ;
                    end
                end
                READ: begin
                    collide <= collide | hit_s;
                    if ((EARLY_EXIT != 0) && hit_s) begin
                        rd_en   <= 1'b0;
                        pend_r  <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else if (cnt_r == 2'd3) begin
                        rd_en   <= 1'b0;
                        pend_r  <= 1'b1;
                        state_r <= DRAIN;
                    end else begin
                        cnt_r   <= cnt_r + 2'd1;
                        rd_addr <= blk_r[cnt_r + 2'd1];
                        pend_r  <= 1'b1;
                    end
                end
                DRAIN: begin
                    collide <= collide | hit_s;
                    pend_r  <= 1'b0;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    rd_en     <= 1'b0;
                    pend_r    <= 1'b0;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
